mdu_sched: RTL and testbench

MDU_SCHED -- requirements
Module: mdu_sched

---
 rtl/mdu_sched.sv | 114 +++++++++++
 tb/tb_mdu_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// mdu_sched: launches one M-extension request on the multiplier or divider and returns a
// registered result. Optional watchdog abort enabled by YSYX22040228_MDU_TIMEOUT_EN.
module mdu_sched #(
  parameter int TIMEOUT_CYC = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_div,
  input  logic        flush,
  output logic        mul_start,
  output logic        div_start,
  input  logic        mul_finish,
  input  logic        div_finish,
  input  logic [63:0] mul_data,
  input  logic [63:0] div_data,
  output logic        res_valid,
  output logic [63:0] res_data,
  output logic        stall_req,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_RUN = 3'd1,
    DIV_RUN = 3'd2,
    DONE    = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t state;
  logic   sel_div;
  logic   done_valid;
  logic   sel_finish;
  logic   running;
  logic   wd_hit;

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("mdu_sched: TIMEOUT_CYC out of range");
  end

  // Only the launched unit's finish matters; the other unit's finish is ignored.
  assign sel_finish = sel_div ? div_finish : mul_finish;
  assign running    = (state == MUL_RUN) || (state == DIV_RUN) || (state == DRAIN);

`ifdef YSYX22040228_MDU_TIMEOUT_EN
  logic [7:0] wd_cnt;
  assign wd_hit = running && (wd_cnt == 8'(TIMEOUT_CYC - 1));
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sel_div    <= 1'b0;
      done_valid <= 1'b0;
      mul_start  <= 1'b0;
      div_start  <= 1'b0;
      res_data   <= '0;
`ifdef YSYX22040228_MDU_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      mul_start  <= 1'b0;
      div_start  <= 1'b0;
      done_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            state     <= req_is_div ? DIV_RUN : MUL_RUN;
            sel_div   <= req_is_div;
            mul_start <= !req_is_div;
            div_start <= req_is_div;
          end
        end
        MUL_RUN, DIV_RUN: begin
          if (wd_hit) begin
            state <= IDLE;
          end else if (flush) begin
            // A unit cannot be cancelled: wait out its finish unless it is already here.
            state <= sel_finish ? IDLE : DRAIN;
          end else if (sel_finish) begin
            res_data   <= sel_div ? div_data : mul_data;
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: state <= IDLE;
        DRAIN: begin
          if (wd_hit || sel_finish) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef YSYX22040228_MDU_TIMEOUT_EN
      if (wd_hit) timeout_err <= 1'b1;
      // Restart the count on every state change so RUN and DRAIN each get the full budget.
      if (!running || wd_hit || (state != DRAIN && (flush || sel_finish)))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 8'd1;
`endif
    end
  end

  assign res_valid = done_valid & ~flush;
  assign stall_req = rst & req_valid & ~res_valid & ~flush;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed scenarios plus randomized requests checked
// against a per-request timing model (accept at t=0, start at t=1, result at lat+2).
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_is_div = 1'b0;
  logic        flush = 1'b0;
  logic        mul_finish = 1'b0;
  logic        div_finish = 1'b0;
  logic [63:0] mul_data = '0;
  logic [63:0] div_data = '0;
  logic        mul_start, div_start, res_valid, stall_req, busy, timeout_err;
  logic [63:0] res_data;

  int          checks = 0;
  int          errors = 0;
  int          op_id  = 0;
  logic [63:0] last_data = '0;

  always #5 clk = ~clk;

  mdu_sched #(.TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_is_div (req_is_div),
    .flush      (flush),
    .mul_start  (mul_start),
    .div_start  (div_start),
    .mul_finish (mul_finish),
    .div_finish (div_finish),
    .mul_data   (mul_data),
    .div_data   (div_data),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .stall_req  (stall_req),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ms, input logic ds, input logic rv,
                           input logic bz, input logic st, input logic [63:0] d, input logic te);
    chk({tag, ".mul_start"}, 64'(mul_start), 64'(ms));
    chk({tag, ".div_start"}, 64'(div_start), 64'(ds));
    chk({tag, ".res_valid"}, 64'(res_valid), 64'(rv));
    chk({tag, ".busy"}, 64'(busy), 64'(bz));
    chk({tag, ".stall_req"}, 64'(stall_req), 64'(st));
    chk({tag, ".res_data"}, res_data, d);
    chk({tag, ".timeout_err"}, 64'(timeout_err), 64'(te));
  endtask

  // Start of a cycle: clear pulses and put random junk on the result buses.
  task automatic cyc_begin();
    @(posedge clk);
    #1;
    flush      = 1'b0;
    mul_finish = 1'b0;
    div_finish = 1'b0;
    mul_data   = {$urandom, $urandom};
    div_data   = {$urandom, $urandom};
  endtask

  // f: -1 no flush, -2 flush in the result cycle, >=1 flush at that cycle of RUN.
  task automatic run_op(input bit is_div, input int lat, input logic [63:0] data,
                        input int f, input bit hold_new, input bit spur);
    int  last_t;
    bit  killed, e_rv, e_done, e_st;
    logic [63:0] e_d;
    last_t = (f < 0) ? lat + 2 : lat + 1;
    op_id++;
    for (int t = 0; t <= last_t; t++) begin
      cyc_begin();
      killed     = (f >= 1) && (t > f);
      req_valid  = killed ? hold_new : 1'b1;
      req_is_div = (killed && hold_new) ? 1'b0 : is_div;
      if (t == f || (f == -2 && t == lat + 2)) flush = 1'b1;
      if (t == 1 + lat) begin
        if (is_div) begin div_finish = 1'b1; div_data = data; end
        else begin mul_finish = 1'b1; mul_data = data; end
      end
      if (spur && $urandom_range(0, 1) == 1) begin
        if (is_div) mul_finish = 1'b1; else div_finish = 1'b1;
      end
      e_done = (f < 0) && (t == lat + 2);
      e_rv   = (f == -1) && (t == lat + 2);
      e_d    = e_done ? data : last_data;
      e_st   = req_valid && !e_rv && !flush;
      @(negedge clk);
      check_all($sformatf("op%0d_t%0d", op_id, t), (t == 1) && !is_div, (t == 1) && is_div,
                e_rv, t >= 1, e_st, e_d, 1'b0);
    end
    if (f < 0) last_data = data;
    $display("op %0d %s lat=%0d flush=%0d data=%h checks=%0d errors=%0d",
             op_id, is_div ? "DIV" : "MUL", lat, f, data, checks, errors);
  endtask

  task automatic idle_cycles(input int n, input bit flush_req);
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      req_valid  = flush_req;
      req_is_div = 1'($urandom_range(0, 1));
      flush      = flush_req;
      mul_finish = 1'($urandom_range(0, 1));
      div_finish = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_all($sformatf("idle_f%0d_%0d", flush_req, i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                last_data, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] d;
    int lat, mode, f;
    bit is_div;

    // Reset state
    @(negedge clk);
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    // MUL, finish 3 cycles after start, result 0x30
    run_op(1'b0, 3, 64'h0000_0000_0000_0030, -1, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);

    // DIV, long latency, all-ones result, spurious mul_finish throughout
`ifdef YSYX22040228_MDU_TIMEOUT_EN
    run_op(1'b1, 10, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b0, 1'b1);
`else
    run_op(1'b1, 65, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b0, 1'b1);
`endif

    // Flush 2 cycles into DIV_RUN, finish 10 cycles later, new MUL held during DRAIN
    run_op(1'b1, 12, 64'hDEAD_BEEF_0000_0001, 3, 1'b1, 1'b0);
    run_op(1'b0, 2, 64'h1234_5678_9ABC_DEF0, -1, 1'b0, 1'b0);

    // Flush in IDLE suppresses the launch
    idle_cycles(1, 1'b1);
    run_op(1'b1, 1, 64'h0000_0000_0000_00A5, -1, 1'b0, 1'b0);

    // Flush in DONE, flush together with finish, finish in the start cycle
    run_op(1'b0, 1, 64'h5555_AAAA_5555_AAAA, -2, 1'b0, 1'b0);
    run_op(1'b0, 4, 64'h0000_0000_0000_0777, 5, 1'b0, 1'b0);
    run_op(1'b0, 0, 64'h0000_0000_0000_0042, -1, 1'b0, 1'b0);
    run_op(1'b1, 0, 64'h0000_0000_0000_0043, -1, 1'b0, 1'b1);

    // Reset in the first MUL_RUN cycle, then a late finish after release
    cyc_begin();
    req_valid = 1'b1; req_is_div = 1'b0;
    @(negedge clk);
    check_all("rst_accept", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last_data, 1'b0);
    cyc_begin();
    chk("rst_pre.mul_start", 64'(mul_start), 64'h1);
    #1 rst = 1'b0;
    #1;
    last_data = '0;
    check_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc_begin();
    mul_finish = 1'b1;
    @(negedge clk);
    check_all("rst_late_finish", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    idle_cycles(1, 1'b0);
    $display("reset-mid-run checks=%0d errors=%0d", checks, errors);

    // Randomized requests
    for (int i = 0; i < 30; i++) begin
      is_div = 1'($urandom_range(0, 1));
      lat    = $urandom_range(0, 12);
      mode   = $urandom_range(0, 5);
      d      = {$urandom, $urandom};
      f      = (mode == 0) ? $urandom_range(1, lat + 1) : (mode == 1) ? -2 : -1;
      run_op(is_div, lat, d, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2), 1'b0);
    end

    // Finish withheld
`ifdef YSYX22040228_MDU_TIMEOUT_EN
    cyc_begin();
    req_valid = 1'b1; req_is_div = 1'b0;
    for (int t = 1; t <= 17; t++) begin
      cyc_begin();
      if (t == 17) req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("wd_t%0d.busy", t), 64'(busy), 64'(t <= 16));
      chk($sformatf("wd_t%0d.res_valid", t), 64'(res_valid), 64'h0);
    end
    chk("wd.timeout_err", 64'(timeout_err), 64'h1);
    cyc_begin();
    chk("wd.sticky", 64'(timeout_err), 64'h1);
    rst = 1'b0;
    #1 chk("wd.cleared", 64'(timeout_err), 64'h0);
    last_data = '0;
    @(posedge clk);
    #1 rst = 1'b1;
`else
    run_op(1'b0, 40, 64'h0000_0000_CAFE_F00D, -1, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
